// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception/interrupt sequencer.
// VECTOR_ADDR is consumed by the PC mux only.
package exc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2,
        HALT    = 2'd3
    } exc_state_e;

    localparam logic [3:0] CAUSE_NONE   = 4'b0000;
    localparam logic [3:0] CAUSE_IRQ    = 4'b0001;
    localparam logic [3:0] CAUSE_INVOP  = 4'b0010;
    localparam logic [3:0] CAUSE_DFAULT = 4'b1111;

    localparam logic [63:0] VECTOR_ADDR = 64'h0000_0000_0000_0200;

endpackage

// File: rtl/exc_sync2.sv
// Generic two-flop synchronizer for a single-bit level signal; both stages reset to 0.
module exc_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer: masked, handshaked exception entry, ESR/ELR and ERET return.
// Define EXC_IRQ_SYNC_EN to pass ExtIRQ through a 2-flop synchronizer (+2 cycles latency).
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ExtIRQ,
    input  logic         InvOp,
    input  logic         ERet,
    input  logic [N-1:0] pc,
    input  logic         ExcAck,
    output logic         Exc,
    output logic         ExtIAck,
    output logic [3:0]   EStatus,
    output logic [N-1:0] ELR,
    output logic         ERetTaken,
    output logic         InHandler,
    output logic         Halted
);

    logic irq_s;

`ifdef EXC_IRQ_SYNC_EN
    exc_sync2 u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ExtIRQ),
        .q     (irq_s)
    );
`else
    assign irq_s = ExtIRQ;
`endif

    exc_state_e   state_q, state_d;
    logic [3:0]   esr_q, esr_d;
    logic [N-1:0] elr_q, elr_d;
    // Marks the first REQ cycle so the interrupt acknowledge is a single pulse.
    logic         first_q, first_d;

    always_comb begin
        state_d = state_q;
        esr_d   = esr_q;
        elr_d   = elr_q;
        first_d = 1'b0;
        case (state_q)
            RUN: begin
                // An ERET seen outside the handler is treated as an invalid opcode.
                if (InvOp || ERet) begin
                    esr_d   = CAUSE_INVOP;
                    elr_d   = pc;
                    state_d = REQ;
                    first_d = 1'b1;
                end else if (irq_s) begin
                    esr_d   = CAUSE_IRQ;
                    elr_d   = pc;
                    state_d = REQ;
                    first_d = 1'b1;
                end
            end
            REQ: begin
                if (ExcAck) begin
                    state_d = HANDLER;
                end
            end
            HANDLER: begin
                if (ERet) begin
                    esr_d   = CAUSE_NONE;
                    state_d = RUN;
                end else if (InvOp) begin
                    esr_d   = CAUSE_DFAULT;
                    state_d = HALT;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            esr_q   <= CAUSE_NONE;
            elr_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            esr_q   <= esr_d;
            elr_q   <= elr_d;
            first_q <= first_d;
        end
    end

    assign Exc       = (state_q == REQ);
    assign ExtIAck   = (state_q == REQ) && first_q && (esr_q == CAUSE_IRQ);
    assign InHandler = (state_q == HANDLER);
    assign Halted    = (state_q == HALT);
    assign ERetTaken = (state_q == HANDLER) && ERet;
    assign EStatus   = esr_q;
    assign ELR       = elr_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the entry/handler/return rules.
module tb_exception_ctrl;

    localparam int M_RUN = 0, M_REQ = 1, M_HANDLER = 2, M_HALT = 3;
`ifdef EXC_IRQ_SYNC_EN
    localparam int IRQ_LAT = 3;
`else
    localparam int IRQ_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ExtIRQ, InvOp, ERet, ExcAck;
    logic [63:0] pc;
    logic        Exc, ExtIAck, ERetTaken, InHandler, Halted;
    logic [3:0]  EStatus;
    logic [63:0] ELR;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode, cause, link, cycles spent in REQ, IRQ delay history.
    int          m_mode;
    logic [3:0]  m_cause;
    logic [63:0] m_link;
    int          m_req_age;
    logic        h0, h1;

    exception_ctrl #(.N(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .ExtIRQ    (ExtIRQ),
        .InvOp     (InvOp),
        .ERet      (ERet),
        .pc        (pc),
        .ExcAck    (ExcAck),
        .Exc       (Exc),
        .ExtIAck   (ExtIAck),
        .EStatus   (EStatus),
        .ELR       (ELR),
        .ERetTaken (ERetTaken),
        .InHandler (InHandler),
        .Halted    (Halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_RUN;
        m_cause   = 4'h0;
        m_link    = 64'h0;
        m_req_age = 0;
        h0        = 1'b0;
        h1        = 1'b0;
    endtask

    task automatic model_enter(input logic [3:0] cause);
        m_mode    = M_REQ;
        m_cause   = cause;
        m_link    = pc;
        m_req_age = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        logic irq_eff;
`ifdef EXC_IRQ_SYNC_EN
        irq_eff = h1;
        h1 = h0;
        h0 = ExtIRQ;
`else
        irq_eff = ExtIRQ;
`endif
        case (m_mode)
            M_RUN: begin
                if (InvOp || ERet) model_enter(4'h2);
                else if (irq_eff)  model_enter(4'h1);
            end
            M_REQ: begin
                m_req_age++;
                if (ExcAck) m_mode = M_HANDLER;
            end
            M_HANDLER: begin
                if (ERet) begin
                    m_mode  = M_RUN;
                    m_cause = 4'h0;
                end else if (InvOp) begin
                    m_mode  = M_HALT;
                    m_cause = 4'hF;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        check_eq("Exc",       Exc,       (m_mode == M_REQ));
        check_eq("ExtIAck",   ExtIAck,   (m_mode == M_REQ) && (m_req_age == 0) && (m_cause == 4'h1));
        check_eq("EStatus",   EStatus,   m_cause);
        check_eq("ELR",       ELR,       m_link);
        check_eq("ERetTaken", ERetTaken, (m_mode == M_HANDLER) && ERet);
        check_eq("InHandler", InHandler, (m_mode == M_HANDLER));
        check_eq("Halted",    Halted,    (m_mode == M_HALT));
    endtask

    // Entered and left at posedge+1; checks at the falling edge, then steps the model.
    task automatic cycle(input logic irq, input logic inv, input logic er, input logic ack,
                         input logic [63:0] p);
        ExtIRQ = irq; InvOp = inv; ERet = er; ExcAck = ack; pc = p;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
        $display("cyc t=%0t irq=%0b inv=%0b eret=%0b ack=%0b pc=%0h -> Exc=%0b IAck=%0b ESR=%0h ELR=%0h InH=%0b Halt=%0b",
                 $time, irq, inv, er, ack, p, Exc, ExtIAck, EStatus, ELR, InHandler, Halted);
    endtask

    // Asserts reset between edges and checks that outputs clear before the next edge.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        ExtIRQ = 1'b0; InvOp = 1'b0; ERet = 1'b0; ExcAck = 1'b0;
        #1;
        model_reset();
        check_eq("rst_Exc",     Exc,     1'b0);
        check_eq("rst_EStatus", EStatus, 4'h0);
        check_eq("rst_ELR",     ELR,     64'h0);
        check_eq("rst_Halted",  Halted,  1'b0);
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("reset pulse applied at t=%0t", $time);
    endtask

    initial begin
        int lat;
        logic irq_r;
        reset = 1'b1;
        ExtIRQ = 1'b0; InvOp = 1'b0; ERet = 1'b0; ExcAck = 1'b0; pc = 64'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("init_Exc",       Exc,       1'b0);
        check_eq("init_ExtIAck",   ExtIAck,   1'b0);
        check_eq("init_EStatus",   EStatus,   4'h0);
        check_eq("init_ELR",       ELR,       64'h0);
        check_eq("init_InHandler", InHandler, 1'b0);
        check_eq("init_Halted",    Halted,    1'b0);

        // IRQ entry, 3-cycle REQ, ERET return.
        lat = 0;
        while (!Exc && lat < 8) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'h40);
            lat++;
        end
        check_eq("irq_latency", lat, IRQ_LAT);
        check_eq("irq_iack", ExtIAck, 1'b1);
        check_eq("irq_esr",  EStatus, 4'h1);
        check_eq("irq_elr",  ELR,     64'h40);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h44);
        check_eq("irq_iack_pulse", ExtIAck, 1'b0);
        check_eq("irq_exc_hold",   Exc,     1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h44);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h44);
        check_eq("irq_inhandler", InHandler, 1'b1);
        ERet = 1'b1;
        #1;
        check_eq("eret_taken_comb", ERetTaken, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h48);
        check_eq("eret_esr_clear", EStatus, 4'h0);
        check_eq("eret_run",       InHandler, 1'b0);

        // InvOp beats ExtIRQ; level IRQ re-enters after ERET.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'h80);
        check_eq("sim_esr",  EStatus, 4'h2);
        check_eq("sim_elr",  ELR,     64'h80);
        check_eq("sim_iack", ExtIAck, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 64'h90);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 64'h94);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'h84);
        check_eq("reentry_exc", Exc,     1'b1);
        check_eq("reentry_esr", EStatus, 4'h1);
        check_eq("reentry_elr", ELR,     64'h84);

        // Masking in HANDLER, then double fault.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h100);
        for (int i = 0; i < 4; i++) begin
            cycle(i[0], 1'b0, 1'b0, 1'b0, 64'h100);
            check_eq("mask_exc",  Exc,       1'b0);
            check_eq("mask_iack", ExtIAck,   1'b0);
            check_eq("mask_inh",  InHandler, 1'b1);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'hDEAD);
        check_eq("df_esr",    EStatus, 4'hF);
        check_eq("df_halted", Halted,  1'b1);
        check_eq("df_exc",    Exc,     1'b0);
        check_eq("df_elr",    ELR,     64'h84);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 64'h200);
        check_eq("df_sticky", Halted, 1'b1);
        async_reset();
        check_eq("df_cleared", Halted, 1'b0);

        // ERET outside the handler is an invalid opcode.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h10);
        check_eq("ill_esr", EStatus, 4'h2);
        check_eq("ill_elr", ELR,     64'h10);
        check_eq("ill_exc", Exc,     1'b1);

        // Reset mid-REQ; a later ExcAck is ignored.
        async_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h20);
        check_eq("ack_ignored_inh", InHandler, 1'b0);
        check_eq("ack_ignored_exc", Exc,       1'b0);

        // Randomized traffic.
        irq_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ((m_mode == M_HALT && $urandom_range(0, 4) == 0) || $urandom_range(0, 149) == 0) begin
                async_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) irq_r = ~irq_r;
                cycle(irq_r,
                      ($urandom_range(0, 15) == 0),
                      ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 2) == 0),
                      {$urandom, $urandom} & ~64'h3);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
